fetch_queue_stage: RTL and testbench

//  Parametrised successor of the single-cycle fetch stage: decouples PC generation from a

---
 rtl/fetch_queue_stage.sv | 196 +++++++++++++++++++
 tb/tb_fetch_queue_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// ============================================================================
//  Module   : fetch_queue_stage
//  Purpose  : Decoupled instruction fetch. PC generation issues valid/ready
//             requests to a variable-latency instruction memory. In-order
//             responses fill a QDEPTH-entry prefetch queue that feeds the
//             IF/ID register. Execute-stage redirects discard wrong-path
//             fetches, both queued and still in flight.
//  Option   : define FETCH_PERF_CNT_EN to add the perf_fetch_cnt and
//             perf_bubble_cnt saturating counter outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_stage #(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  localparam int              PTR_W   = $clog2(QDEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  // Back-to-back redirects can leave more than QDEPTH wrong-path responses
  // owed by the memory, so the discard counter is deliberately wide.
  localparam int              DROP_W  = 16;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]   fpc_q, fpc_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [XLEN-1:0]   qpc_q   [QDEPTH];
  logic [XLEN-1:0]   qdata_q [QDEPTH];

  logic [XLEN-1:0]   instr_q, pc_q, pcplus4_q;
  logic              valid_q;

  logic              w_credit_ok;
  logic              w_req_valid;
  logic              w_accept;
  logic              w_rsp_good;
  logic              w_rsp_drop;
  logic              w_enq;
  logic              w_deq;
  logic              w_load_bubble;

  // Request credit counts both queued entries and correct-path requests in flight.
  assign w_credit_ok   = ({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(QDEPTH);
  assign w_req_valid   = !PCSrcE && w_credit_ok;
  assign w_accept      = w_req_valid && imem_req_ready;
  assign w_rsp_drop    = imem_rsp_valid && (drop_q != '0);
  assign w_rsp_good    = imem_rsp_valid && (drop_q == '0);
  assign w_enq         = w_rsp_good && !PCSrcE;
  assign w_deq         = !FlushD && !StallD && (count_q != '0);
  assign w_load_bubble = !FlushD && !StallD && (count_q == '0);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = fpc_q;
  assign InstrD         = instr_q;
  assign PCD            = pc_q;
  assign PCPlus4D       = pcplus4_q;
  assign ValidD         = valid_q;

  // Next-state for fetch/response PCs, queue pointers and outstanding-request bookkeeping.
  always_comb begin
    fpc_d      = fpc_q;
    rpc_d      = rpc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (PCSrcE) begin
      // Everything still owed by memory becomes wrong-path; a response
      // arriving this cycle is one of those and is consumed here.
      fpc_d      = PCTargetE;
      rpc_d      = PCTargetE;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = '0;
      drop_d     = drop_q + DROP_W'(inflight_q) - DROP_W'(imem_rsp_valid);
    end else begin
      if (w_accept) fpc_d = fpc_q + PC_STEP;
      if (w_enq) begin
        rpc_d  = rpc_q + PC_STEP;
        tail_d = tail_q + PTR_W'(1);
      end
      if (w_deq) head_d = head_q + PTR_W'(1);
      count_d    = count_q + CNT_W'(w_enq) - CNT_W'(w_deq);
      inflight_d = inflight_q + CNT_W'(w_accept) - CNT_W'(w_rsp_good);
      drop_d     = drop_q - DROP_W'(w_rsp_drop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_q      <= RESET_PC;
      rpc_q      <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fpc_q      <= fpc_d;
      rpc_q      <= rpc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      qpc_q[tail_q]   <= rpc_q;
      qdata_q[tail_q] <= imem_rsp_data;
    end
  end

  // IF/ID register: reset, then flush, then stall, then pop head or bubble.
  always_ff @(posedge clk) begin
    if (!rst || FlushD) begin
      instr_q   <= '0;
      pc_q      <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (!StallD) begin
      if (count_q != '0) begin
        instr_q   <= qdata_q[head_q];
        pc_q      <= qpc_q[head_q];
        pcplus4_q <= qpc_q[head_q] + PC_STEP;
        valid_q   <= 1'b1;
      end else begin
        instr_q   <= '0;
        pc_q      <= '0;
        pcplus4_q <= '0;
        valid_q   <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_bubble_q;

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;

  // Saturating counts of enqueued fetches and empty-queue bubbles loaded into IF/ID.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (w_enq && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (w_load_bubble && (perf_bubble_q != '1)) perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end
`else
  // Without the counters the bubble indication has no consumer.
  logic w_unused;
  assign w_unused = w_load_bubble;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
// ============================================================================
//  Module   : tb_fetch_queue_stage
//  Purpose  : Self-checking bench for fetch_queue_stage: a directed
//             cycle table followed by randomized traffic against a
//             queue-based reference model and an in-order memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue_stage;

  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, PCSrcE, StallD, FlushD;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

  fetch_queue_stage #(.XLEN(32), .QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Memory contents: a fixed scramble of the address, never zero for small PCs.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h3C5A_9600;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_decode(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] eins);
    chk({tag, " ValidD"},   {31'b0, ValidD}, {31'b0, ev});
    chk({tag, " PCD"},      PCD,      ev ? epc : 32'h0);
    chk({tag, " InstrD"},   InstrD,   ev ? eins : 32'h0);
    chk({tag, " PCPlus4D"}, PCPlus4D, ev ? epc + 32'd4 : 32'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst, ready, rsp_v;
    logic [31:0] rsp_d;
    logic        src;
    logic [31:0] tgt;
    logic        stall, flush;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_v;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic s, input logic [31:0] t, input logic st, input logic fl,
                     input logic erv, input logic [31:0] era, input logic ev,
                     input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.ready = rdy; v.rsp_v = rv; v.rsp_d = rd; v.src = s; v.tgt = t;
    v.stall = st; v.flush = fl; v.e_rv = erv; v.e_ra = era; v.e_v = ev; v.e_pc = epc;
    tbl.push_back(v);
  endtask

  // ---------------- random-phase model ----------------
  typedef struct { logic [31:0] addr; int ep; int cyc; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

  pend_t       pend[$];
  ent_t        mq[$];
  int          epoch;
  logic [31:0] exp_fpc;
  logic        m_v;
  logic [31:0] m_pc, m_ins;
  int          n_enq;
  int          n_dec;

  function automatic int good_inflight();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) n++;
    return n;
  endfunction

  task automatic model_reset();
    pend.delete();
    mq.delete();
    epoch++;
    exp_fpc = 32'h0;
    m_v = 1'b0; m_pc = 32'h0; m_ins = 32'h0;
    n_enq = 0;
  endtask

  initial begin : main
    int cyc;
    int stall_pct;
    logic exp_rv, acc;
    pend_t p;
    ent_t  e;

    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    epoch = 0; n_dec = 0;

    //    rst rdy rv  rsp_d               src tgt           st fl  erv era           ev epc
    add(0, 0, 0, 0,                 0, 0,            0, 0,  1, 32'h0,        0, 0);
    add(1, 1, 0, 0,                 0, 0,            0, 0,  1, 32'h0,        0, 0);
    add(1, 1, 1, imem(32'h0),       0, 0,            0, 0,  1, 32'h4,        0, 0);
    add(1, 1, 1, imem(32'h4),       0, 0,            0, 0,  1, 32'h8,        0, 0);
    add(1, 0, 1, imem(32'h8),       0, 0,            0, 0,  1, 32'hC,        1, 32'h0);
    add(1, 0, 0, 0,                 0, 0,            1, 1,  1, 32'hC,        1, 32'h4);
    add(1, 0, 0, 0,                 0, 0,            1, 0,  1, 32'hC,        0, 0);
    add(1, 0, 0, 0,                 0, 0,            0, 0,  1, 32'hC,        0, 0);
    add(1, 0, 0, 0,                 0, 0,            0, 0,  1, 32'hC,        1, 32'h8);
    add(1, 1, 0, 0,                 1, 32'hFFFFFFFC, 0, 1,  0, 32'hC,        0, 0);
    add(1, 1, 0, 0,                 0, 0,            0, 0,  1, 32'hFFFFFFFC, 0, 0);
    add(1, 1, 1, imem(32'hFFFFFFFC),0, 0,            0, 0,  1, 32'h0,        0, 0);
    add(1, 0, 1, imem(32'h0),       0, 0,            0, 0,  1, 32'h4,        0, 0);
    add(1, 0, 0, 0,                 0, 0,            0, 0,  1, 32'h4,        1, 32'hFFFFFFFC);
    add(1, 0, 0, 0,                 0, 0,            0, 0,  1, 32'h4,        1, 32'h0);
    add(1, 1, 0, 0,                 0, 0,            0, 0,  1, 32'h4,        0, 0);
    add(1, 1, 0, 0,                 0, 0,            0, 0,  1, 32'h8,        0, 0);
    add(1, 1, 0, 0,                 0, 0,            0, 0,  1, 32'hC,        0, 0);
    add(1, 1, 1, imem(32'h4),       1, 32'h100,      0, 1,  0, 32'h10,       0, 0);
    add(1, 1, 1, imem(32'h8),       0, 0,            0, 0,  1, 32'h100,      0, 0);
    add(1, 0, 1, imem(32'hC),       0, 0,            0, 0,  1, 32'h104,      0, 0);
    add(1, 0, 1, imem(32'h100),     0, 0,            0, 0,  1, 32'h104,      0, 0);
    add(1, 0, 0, 0,                 0, 0,            0, 0,  1, 32'h104,      0, 0);
    add(1, 0, 0, 0,                 0, 0,            0, 0,  1, 32'h104,      1, 32'h100);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; imem_req_ready = tbl[i].ready;
      imem_rsp_valid = tbl[i].rsp_v; imem_rsp_data = tbl[i].rsp_d;
      PCSrcE = tbl[i].src; PCTargetE = tbl[i].tgt;
      StallD = tbl[i].stall; FlushD = tbl[i].flush;
      @(negedge clk);
      chk($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
      chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_ra);
      chk_decode($sformatf("row%0d", i), tbl[i].e_v, tbl[i].e_pc, imem(tbl[i].e_pc));
    end

    // ---------------- randomized traffic ----------------
    model_reset();
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      stall_pct = ((cyc / 300) % 3 == 0) ? 10 : (((cyc / 300) % 3 == 1) ? 50 : 85);
      rst = (cyc == 0) ? 1'b0 : (($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1);
      if (rst && pend.size() > 0 && pend[0].cyc < cyc && $urandom_range(0, 99) < 60) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = imem(pend[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
      end
      PCSrcE = rst && ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 3) == 0) PCTargetE = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
      else PCTargetE = $urandom() & 32'hFFFF_FFFC;
      FlushD = PCSrcE || ($urandom_range(0, 99) < 5);
      StallD = ($urandom_range(0, 99) < stall_pct);
      imem_req_ready = ($urandom_range(0, 99) < 70);

      @(negedge clk);
      if (cyc > 0) begin
        exp_rv = !PCSrcE && ((mq.size() + good_inflight()) < QDEPTH);
        chk("rnd req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("rnd req_addr", imem_req_addr, exp_fpc);
        chk_decode("rnd", m_v, m_pc, m_ins);
        if (m_v) n_dec++;
      end
      acc = rst && imem_req_valid && imem_req_ready;

      if (!rst) begin
        model_reset();
      end else begin
        if (FlushD) begin
          m_v = 1'b0; m_pc = 32'h0; m_ins = 32'h0;
        end else if (!StallD) begin
          if (mq.size() > 0) begin
            e = mq.pop_front();
            m_v = 1'b1; m_pc = e.pc; m_ins = e.ins;
          end else begin
            m_v = 1'b0; m_pc = 32'h0; m_ins = 32'h0;
          end
        end
        if (imem_rsp_valid && pend.size() > 0) begin
          p = pend.pop_front();
          if (!PCSrcE && p.ep == epoch) begin
            e.pc = p.addr; e.ins = imem(p.addr);
            mq.push_back(e);
            n_enq++;
          end
        end
        if (acc) begin
          p.addr = exp_fpc; p.ep = epoch; p.cyc = cyc;
          pend.push_back(p);
          exp_fpc = exp_fpc + 32'd4;
        end
        if (PCSrcE) begin
          mq.delete();
          epoch++;
          exp_fpc = PCTargetE;
        end
      end
    end

    // Forward progress: the random run must actually deliver instructions to decode.
    n_vec++;
    if (n_dec < 200) begin
      n_bad++;
      $display("FAIL progress: got %0d decoded instructions expected at least 200", n_dec);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(n_enq));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
